// File: rtl/kernel_led_timer_pkg.sv
// rtl/kernel_led_timer_pkg.sv - register map, control bits and FSM states for the interval-timer master
// Snapshot states exist only when TIMER_SNAP_EN is defined.
package kernel_led_timer_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  localparam logic [31:0] MIN_PERIOD = 32'd8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RUN,
    ST_CLR_ST,
    ST_WR_STOP
`ifdef TIMER_SNAP_EN
    ,
    ST_SNAP_W,
    ST_SNAP_RL,
    ST_SNAP_RH,
    ST_SNAP_CAP
`endif
  } state_t;

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/kernel_led_timer_tickdiv.sv
// rtl/kernel_led_timer_tickdiv.sv - divides timer timeouts into an LED toggle and a tick pulse
// led and tick change in the cycle after the timeout strobe.
module kernel_led_timer_tickdiv #(
  parameter int TICK_DIV = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic timeout,
  input  logic clear,
  output logic led,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      led   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (timeout) begin
        if (count == CW'(TICK_DIV - 1)) begin
          count <= '0;
          led   <= ~led;
          tick  <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kernel_led_timer_master.sv
// rtl/kernel_led_timer_master.sv - Avalon-MM initiator that programs and services the interval timer
// Define TIMER_SNAP_EN to enable the counter snapshot path (snap_req/snap_value/snap_valid).
module kernel_led_timer_master
  import kernel_led_timer_pkg::*;
#(
  parameter logic [31:0] PERIOD   = 32'd99999,
  parameter int          TICK_DIV = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_period,
  input  logic        cfg_period_vld,
  input  logic        snap_req,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        m_irq,
  output logic        busy,
  output logic        led,
  output logic        tick,
  output logic [31:0] snap_value,
  output logic        snap_valid
);

  state_t      state, next_state;
  logic [31:0] shadow;
  logic [31:0] period_w;
  logic        stop_pending;
  logic        after_clr;
  logic        timeout;
  logic        tick_clear;
  logic        bus_cs, bus_wn;
  logic [2:0]  bus_addr;
  logic [15:0] bus_data;

  assign period_w = clamp_period(shadow);

  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      ST_IDLE:    if (start) next_state = ST_WR_PL;
      ST_WR_PL:   next_state = ST_WR_PH;
      ST_WR_PH:   next_state = ST_WR_CTRL;
      ST_WR_CTRL: next_state = (stop || stop_pending) ? ST_WR_STOP : ST_RUN;
      ST_RUN: begin
        // m_irq is still high the cycle after the status clear, so skip it once
        if (stop || stop_pending) begin
          next_state = ST_WR_STOP;
        end else if (m_irq && !after_clr) begin
          next_state = ST_CLR_ST;
          timeout    = 1'b1;
        end
`ifdef TIMER_SNAP_EN
        else if (snap_req) begin
          next_state = ST_SNAP_W;
        end
`endif
      end
      ST_CLR_ST:   next_state = ST_RUN;
      ST_WR_STOP:  next_state = ST_IDLE;
`ifdef TIMER_SNAP_EN
      ST_SNAP_W:   next_state = ST_SNAP_RL;
      ST_SNAP_RL:  next_state = ST_SNAP_RH;
      ST_SNAP_RH:  next_state = ST_SNAP_CAP;
      ST_SNAP_CAP: next_state = ST_RUN;
`endif
      default:     next_state = ST_IDLE;
    endcase
  end

  assign tick_clear = (next_state == ST_WR_STOP) && (state != ST_WR_STOP);

  // Bus fields are decoded from the next state so the registered outputs line up with it
  always_comb begin
    bus_cs   = 1'b1;
    bus_wn   = 1'b0;
    bus_addr = ADDR_STATUS;
    bus_data = 16'h0000;
    case (next_state)
      ST_WR_PL: begin
        bus_addr = ADDR_PERIOD_L;
        bus_data = period_w[15:0];
      end
      ST_WR_PH: begin
        bus_addr = ADDR_PERIOD_H;
        bus_data = period_w[31:16];
      end
      ST_WR_CTRL: begin
        bus_addr = ADDR_CONTROL;
        bus_data = CTRL_ITO | CTRL_CONT | CTRL_START;
      end
      ST_CLR_ST: bus_addr = ADDR_STATUS;
      ST_WR_STOP: begin
        bus_addr = ADDR_CONTROL;
        bus_data = CTRL_STOP;
      end
`ifdef TIMER_SNAP_EN
      ST_SNAP_W:  bus_addr = ADDR_SNAP_L;
      ST_SNAP_RL: begin
        bus_wn   = 1'b1;
        bus_addr = ADDR_SNAP_L;
      end
      ST_SNAP_RH: begin
        bus_wn   = 1'b1;
        bus_addr = ADDR_SNAP_H;
      end
`endif
      default: begin
        bus_cs = 1'b0;
        bus_wn = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      m_address    <= ADDR_STATUS;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= 16'h0000;
      busy         <= 1'b0;
      shadow       <= PERIOD;
      stop_pending <= 1'b0;
      after_clr    <= 1'b0;
    end else begin
      state        <= next_state;
      m_address    <= bus_addr;
      m_chipselect <= bus_cs;
      m_write_n    <= bus_wn;
      m_writedata  <= bus_data;
      busy         <= (next_state != ST_IDLE);
      after_clr    <= (state == ST_CLR_ST);
      if (cfg_period_vld) shadow <= cfg_period;
      if (next_state == ST_WR_STOP || next_state == ST_IDLE) stop_pending <= 1'b0;
      else if (stop && state != ST_IDLE) stop_pending <= 1'b1;
    end
  end

  kernel_led_timer_tickdiv #(
    .TICK_DIV(TICK_DIV)
  ) u_tickdiv (
    .clk     (clk),
    .reset   (reset),
    .timeout (timeout),
    .clear   (tick_clear),
    .led     (led),
    .tick    (tick)
  );

`ifdef TIMER_SNAP_EN
  logic [15:0] snap_lo;
  logic [31:0] snap_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_lo  <= 16'h0000;
      snap_reg <= 32'h0;
    end else begin
      if (state == ST_SNAP_RH) snap_lo <= m_readdata;
      if (state == ST_SNAP_CAP) snap_reg <= {m_readdata, snap_lo};
    end
  end

  // High half arrives in SNAP_CAP itself, so the pulse cycle forwards it directly
  assign snap_valid = (state == ST_SNAP_CAP);
  assign snap_value = snap_valid ? {m_readdata, snap_lo} : snap_reg;
`else
  logic unused_snap;
  assign unused_snap = ^{snap_req, m_readdata};
  assign snap_value  = 32'h0;
  assign snap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_led_timer_master.sv
// tb/tb_kernel_led_timer_master.sv - directed and randomized self-checking bench for kernel_led_timer_master
module tb_kernel_led_timer_master;

  localparam int          TB_TICK_DIV = 2;
  localparam logic [31:0] TB_PERIOD   = 32'd99999;
`ifdef TIMER_SNAP_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif
  localparam logic [2:0] K_CFG = 3'd0, K_CTRL = 3'd1, K_CLR = 3'd2, K_STOP = 3'd3, K_SNAP = 3'd4, K_CAP = 3'd5;

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [2:0]  kind;
  } op_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, cfg_period_vld = 1'b0, snap_req = 1'b0;
  logic [31:0] cfg_period = 32'h0;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata = 16'h0;
  logic        m_irq = 1'b0;
  logic        busy, led, tick, snap_valid;
  logic [31:0] snap_value;
  logic        irq_gen = 1'b0;
  logic [31:0] slv_next = 32'h0, slv_snap = 32'h0;

  int n_cmp = 0, n_bad = 0;
  int tick_seen = 0, clr_seen = 0;

  always #5 clk = ~clk;

  kernel_led_timer_master #(
    .PERIOD   (TB_PERIOD),
    .TICK_DIV (TB_TICK_DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .cfg_period     (cfg_period),
    .cfg_period_vld (cfg_period_vld),
    .snap_req       (snap_req),
    .m_address      (m_address),
    .m_chipselect   (m_chipselect),
    .m_write_n      (m_write_n),
    .m_writedata    (m_writedata),
    .m_readdata     (m_readdata),
    .m_irq          (m_irq),
    .busy           (busy),
    .led            (led),
    .tick           (tick),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timer slave: level irq cleared by a status write, snapshot latched by a snap_l write
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_irq      <= 1'b0;
      m_readdata <= 16'h0;
    end else begin
      if (m_chipselect && !m_write_n && m_address == 3'd0) m_irq <= 1'b0;
      else if (irq_gen) m_irq <= 1'b1;
      if (m_chipselect && !m_write_n && m_address == 3'd4) slv_snap <= slv_next;
      if (m_chipselect && m_write_n && m_address == 3'd4) m_readdata <= slv_snap[15:0];
      else if (m_chipselect && m_write_n && m_address == 3'd5) m_readdata <= slv_snap[31:16];
      else m_readdata <= 16'h0;
    end
  end

  always @(negedge clk) begin
    if (!reset && tick) tick_seen++;
    if (!reset && m_chipselect && !m_write_n && m_address == 3'd0) clr_seen++;
  end

  // Reference model: a plan of pending bus cycles plus tick/led arithmetic
  op_t         plan[$];
  bit          active = 1'b0, stop_pend = 1'b0, mask = 1'b0, led_m = 1'b0;
  int          tcnt = 0;
  logic [31:0] shadow_m = TB_PERIOD, snap_m = 32'h0;

  function automatic op_t mk(input logic cs, input logic wn, input logic [2:0] a, input logic [15:0] d, input logic [2:0] k);
    op_t o;
    o.cs = cs; o.wn = wn; o.addr = a; o.data = d; o.kind = k;
    return o;
  endfunction

  task automatic sched_stop();
    plan.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0008, K_STOP));
    stop_pend = 1'b0;
    tcnt = 0;
  endtask

  always @(negedge clk) begin : model
    op_t h;
    bit has, tick_e, snapv_e;
    logic [31:0] p;
    tick_e = 1'b0;
    snapv_e = 1'b0;
    if (reset) begin
      plan.delete();
      active = 1'b0; stop_pend = 1'b0; mask = 1'b0; led_m = 1'b0;
      tcnt = 0; shadow_m = TB_PERIOD; snap_m = 32'h0;
    end
    has = (plan.size() > 0);
    h = has ? plan[0] : mk(1'b0, 1'b1, 3'd0, 16'h0, K_CFG);
    if (has && h.kind == K_CLR) begin
      tcnt++;
      if (tcnt == TB_TICK_DIV) begin
        tcnt = 0;
        led_m = !led_m;
        tick_e = 1'b1;
      end
    end
    if (has && h.kind == K_CAP) begin
      snap_m = slv_snap;
      snapv_e = 1'b1;
    end
    chk("bus", 64'({m_chipselect, m_write_n, m_address, m_writedata}), 64'({h.cs, h.wn, h.addr, h.data}));
    chk("busy_led_tick", 64'({busy, led, tick, snap_valid}), 64'({active, led_m, tick_e, snapv_e}));
    chk("snap_value", 64'(snap_value), 64'(snap_m));
    if (!reset) begin
      if (active) stop_pend = stop_pend | stop;
      if (has) begin
        void'(plan.pop_front());
        if (plan.size() == 0) begin
          if (h.kind == K_STOP) begin
            active = 1'b0;
            stop_pend = 1'b0;
          end else if (h.kind == K_CTRL && stop_pend) begin
            sched_stop();
          end
        end
        mask = (h.kind == K_CLR);
      end else if (active) begin
        if (stop_pend) sched_stop();
        else if (m_irq && !mask) plan.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0, K_CLR));
        else if (SNAP_EN && snap_req) begin
          plan.push_back(mk(1'b1, 1'b0, 3'd4, 16'h0, K_SNAP));
          plan.push_back(mk(1'b1, 1'b1, 3'd4, 16'h0, K_SNAP));
          plan.push_back(mk(1'b1, 1'b1, 3'd5, 16'h0, K_SNAP));
          plan.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0, K_CAP));
        end
        mask = 1'b0;
      end else begin
        if (start) begin
          active = 1'b1;
          p = (shadow_m < 32'd8) ? 32'd8 : shadow_m;
          plan.push_back(mk(1'b1, 1'b0, 3'd2, p[15:0], K_CFG));
          plan.push_back(mk(1'b1, 1'b0, 3'd3, p[31:16], K_CFG));
          plan.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0007, K_CTRL));
        end
        mask = 1'b0;
      end
      if (cfg_period_vld) shadow_m = cfg_period;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic chk_bus(input string nm, input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chk(nm, 64'({m_chipselect, m_write_n, m_address, m_writedata}), 64'({1'b1, 1'b0, a, d}));
  endtask

  task automatic load_cfg(input logic [31:0] v);
    cfg_period = v;
    cfg_period_vld = 1'b1;
    next_cycle();
    cfg_period_vld = 1'b0;
  endtask

  initial begin : stim
    int t0, c0;
    @(negedge clk);
    chk("reset_state", 64'({m_chipselect, m_write_n, m_address, m_writedata, busy, led, tick, snap_valid}),
        64'({1'b0, 1'b1, 3'd0, 16'h0, 4'b0000}));
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Default shadow 99999 = 0x0001_869F
    pulse_start();
    chk_bus("default_pl", 3'd2, 16'h869F);
    chk("busy_cycle1", 64'(busy), 64'(1));
    next_cycle();
    chk_bus("default_ph", 3'd3, 16'h0001);
    next_cycle();
    chk_bus("default_ctrl", 3'd1, 16'h0007);
    next_cycle();
    @(negedge clk);
    chk("run_idle_bus", 64'({busy, m_chipselect}), 64'({1'b1, 1'b0}));

    // Three timeouts with TICK_DIV=2: one led toggle, one tick
    t0 = tick_seen;
    c0 = clr_seen;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      irq_gen = 1'b1;
      next_cycle();
      irq_gen = 1'b0;
      repeat (6) next_cycle();
    end
    @(negedge clk);
    chk("led_after_3_irq", 64'(led), 64'(1));
    chk("ticks_after_3_irq", 64'(tick_seen - t0), 64'(1));
    chk("status_writes", 64'(clr_seen - c0), 64'(3));

    next_cycle();
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    chk_bus("stop_write", 3'd1, 16'h0008);
    repeat (2) next_cycle();
    @(negedge clk);
    chk("idle_after_stop", 64'({busy, led}), 64'({1'b0, 1'b1}));

    next_cycle();
    load_cfg(32'h0002_0005);
    pulse_start();
    chk_bus("cfg_pl", 3'd2, 16'h0005);
    next_cycle();
    chk_bus("cfg_ph", 3'd3, 16'h0002);
    next_cycle();
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    repeat (4) next_cycle();

    // Small period clamps to 8; stop during WR_PH completes the sequence first
    load_cfg(32'd3);
    pulse_start();
    chk_bus("clamp_pl", 3'd2, 16'h0008);
    next_cycle();
    stop = 1'b1;
    chk_bus("clamp_ph", 3'd3, 16'h0000);
    next_cycle();
    stop = 1'b0;
    chk_bus("pend_ctrl", 3'd1, 16'h0007);
    next_cycle();
    chk_bus("pend_stop", 3'd1, 16'h0008);
    next_cycle();
    @(negedge clk);
    chk("pend_idle", 64'(busy), 64'(0));
    next_cycle();

`ifdef TIMER_SNAP_EN
    pulse_start();
    repeat (5) next_cycle();
    slv_next = 32'h0001_1234;
    snap_req = 1'b1;
    next_cycle();
    snap_req = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("snap_valid_n4", 64'(snap_valid), 64'(1));
    chk("snap_value_n4", 64'(snap_value), 64'h0001_1234);
    next_cycle();
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    repeat (4) next_cycle();
`endif

    // Reset mid-sequence returns the bus to idle at once
    pulse_start();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_bus", 64'({m_chipselect, m_write_n, m_writedata, busy}), 64'({1'b0, 1'b1, 16'h0, 1'b0}));
    next_cycle();
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      irq_gen  = ($urandom_range(0, 7) == 0);
      snap_req = ($urandom_range(0, 14) == 0);
      slv_next = $urandom;
      cfg_period_vld = 1'b0;
      if (((!active && !start) || (active && plan.size() == 0)) && $urandom_range(0, 9) == 0) begin
        cfg_period_vld = 1'b1;
        cfg_period = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      end
      reset = ($urandom_range(0, 799) == 0);
      next_cycle();
    end
    start = 1'b0; stop = 1'b0; irq_gen = 1'b0; snap_req = 1'b0; cfg_period_vld = 1'b0; reset = 1'b0;
    repeat (10) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
